// File: rtl/data_memory_bytelane_if.sv
// data_memory_bytelane_if
//   MEM-stage request/response bundle between the pipeline and the data
//   memory.
//   Request:  mem_read, mem_write, funct3, address, data_write
//   Response: data_read, rd_valid, busy, fault, fault_cause
//   The slave modport is the memory side and the master modport is the
//   pipeline side.
`timescale 1ns/1ps
interface data_memory_bytelane_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        rd_valid;
  logic        busy;
  logic        fault;
  logic [1:0]  fault_cause;

  modport master (
    output mem_read, mem_write, funct3, address, data_write,
    input  data_read, rd_valid, busy, fault, fault_cause
  );

  modport slave (
    input  mem_read, mem_write, funct3, address, data_write,
    output data_read, rd_valid, busy, fault, fault_cause
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane
//   RV32I MEM-stage data memory of DEPTH 32-bit words.
//   - Byte, half and word stores are written through byte-lane enables.
//   - Loads are sign- or zero-extended.
//   - Every request is checked for illegal funct3, misalignment and range.
//   - After reset the array is optionally zeroed, one word per cycle, and busy
//     stalls the pipeline while that runs.
//   Ports:
//     clk, rst_n : clock (rising edge) and asynchronous active-low reset
//     bus        : data_memory_bytelane_if.slave
//                  request:  mem_read/mem_write/funct3/address/data_write
//                  response: data_read/rd_valid/busy/fault/fault_cause
`timescale 1ns/1ps
module data_memory_bytelane #(
  parameter int DEPTH          = 256,
  parameter int READ_LATENCY   = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter int ZERO_WORD0     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  data_memory_bytelane_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic [31:0]   mem [DEPTH];

  logic          busy;
  logic          req;
  logic [AW-1:0] idx;
  logic          idx_zero;
  logic          illegal;
  logic          misaligned;
  logic          out_of_range;
  logic [1:0]    cause;
  logic          accepted;
  logic          ld_ok;
  logic          st_ok;
  logic [31:0]   rd_word;
  logic [31:0]   ld_data;
  logic [3:0]    wr_be;
  logic [31:0]   wr_lane;

  // Extract the addressed byte or half from a word and extend it as the load
  // type demands.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0]        shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    shifted = word >> {lane, 3'b000};
    b_s     = shifted[7:0];
    h_s     = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return 32'(b_s);
      3'b100:  return {24'd0, b_s};
      3'b001:  return 32'(h_s);
      3'b101:  return {16'd0, h_s};
      default: return word;
    endcase
  endfunction

  assign busy     = (state == ST_CLEAR);
  assign req      = bus.mem_read | bus.mem_write;
  assign idx      = bus.address[AW+1:2];
  assign idx_zero = (ZERO_WORD0 != 0) && (idx == '0);

  // Request checks. Unsigned loads have no store counterpart, so
  // funct3 100/101 is illegal whenever a store is part of the request.
  always_comb begin
    case (bus.funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = bus.mem_write;
      default:                illegal = 1'b1;
    endcase
    case (bus.funct3[1:0])
      2'b01:   misaligned = bus.address[0];
      2'b10:   misaligned = (bus.address[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    out_of_range = |bus.address[31:AW+2];
    if (!req || busy)      cause = 2'b00;
    else if (illegal)      cause = 2'b11;
    else if (misaligned)   cause = 2'b01;
    else if (out_of_range) cause = 2'b10;
    else                   cause = 2'b00;
  end

  assign accepted = req && !busy && (cause == 2'b00);
  assign ld_ok    = accepted && bus.mem_read;
  assign st_ok    = accepted && bus.mem_write && !idx_zero;

  assign bus.fault       = (cause != 2'b00);
  assign bus.fault_cause = cause;
  assign bus.busy        = busy;

  // The read happens before the clock edge that performs the store. A
  // combined load and store therefore sees the old contents at either
  // latency.
  assign rd_word = idx_zero ? '0 : mem[idx];
  assign ld_data = load_extend(rd_word, bus.address[1:0], bus.funct3);

  // Store data is replicated across lanes so that the lane enables alone
  // pick the destination bytes.
  always_comb begin
    wr_be   = 4'b0000;
    wr_lane = bus.data_write;
    case (bus.funct3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << bus.address[1:0];
        wr_lane = {4{bus.data_write[7:0]}};
      end
      2'b01: begin
        wr_be   = bus.address[1] ? 4'b1100 : 4'b0011;
        wr_lane = {2{bus.data_write[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_lane = bus.data_write;
      end
    endcase
  end

  // Storage: the clear sequencer owns the write port while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (st_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_lane[8*b +: 8];
      end
    end
  end

  // Clear sequencer: one word per cycle, word 0 first, DEPTH cycles total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == AW'(DEPTH - 1)) state <= ST_READY;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_rd_reg
      logic [31:0] data_read_p1;
      logic        vld_p1;

      // Stage p0 -> p1: capture the extended load result at the clock edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_read_p1 <= '0;
          vld_p1       <= 1'b0;
        end else begin
          vld_p1 <= ld_ok;
          if (ld_ok) data_read_p1 <= ld_data;
        end
      end

      assign bus.data_read = busy ? '0 : data_read_p1;
      assign bus.rd_valid  = vld_p1 && !busy;
    end else begin : g_rd_comb
      assign bus.data_read = ld_ok ? ld_data : '0;
      assign bus.rd_valid  = ld_ok;
    end
  endgenerate

endmodule

// File: tb/tb_data_memory_bytelane.sv
`timescale 1ns/1ps
module tb_data_memory_bytelane;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_memory_bytelane_if bus0 ();
  data_memory_bytelane_if bus1 ();

  data_memory_bytelane #(.DEPTH(256), .READ_LATENCY(0), .CLEAR_ON_RESET(1), .ZERO_WORD0(1))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  data_memory_bytelane #(.DEPTH(256), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .ZERO_WORD0(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_rd1 = '0;
  int          c0, c1;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus0.mem_read = rd;  bus1.mem_read = rd;
    bus0.mem_write = wr; bus1.mem_write = wr;
    bus0.funct3 = f3;    bus1.funct3 = f3;
    bus0.address = addr; bus1.address = addr;
    bus0.data_write = wd; bus1.data_write = wd;
  endtask

  task automatic idle();
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
  endtask

  // One request cycle: immediate checks on the latency-0 instance, expected
  // load data queued for the latency-1 instance one cycle later.
  task automatic do_req(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_d,
                        input logic [1:0] exp_c);
    logic       exp_f;
    logic [31:0] exp_dr;
    exp_t       e;
    exp_f  = (exp_c != 2'b00);
    exp_dr = (rd && !exp_f) ? exp_d : 32'h0;
    @(posedge clk);
    #1 drive(rd, wr, f3, addr, wd);
    #3;
    check({tag, "_fault0"}, bus0.fault, exp_f);
    check({tag, "_cause0"}, bus0.fault_cause, exp_c);
    check({tag, "_cause1"}, bus1.fault_cause, exp_c);
    check({tag, "_vld0"}, bus0.rd_valid, rd && !exp_f);
    check({tag, "_data0"}, bus0.data_read, exp_dr);
    if (rd && !exp_f) begin
      e.due  = cyc + 1;
      e.data = exp_d;
      sb_q.push_back(e);
    end
  endtask

  // Latency-1 scoreboard: rd_valid exactly when a queued result falls due,
  // otherwise data_read must hold the last result.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        check("l1_vld", bus1.rd_valid, 1'b1);
        check("l1_data", bus1.data_read, e.data);
        last_rd1 = e.data;
      end else begin
        check("l1_idle_vld", bus1.rd_valid, 1'b0);
        check("l1_hold", bus1.data_read, last_rd1);
      end
    end
  end

  // Count busy cycles of both instances; optionally stop early or inject a
  // request while busy.
  task automatic wait_busy(input int stop_at, input int inject_at,
                           output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus0.busy && !bus1.busy) break;
      if (bus0.busy) n0++;
      if (bus1.busy) n1++;
      if (n0 == inject_at + 1 && inject_at >= 0) drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
      if (n0 == inject_at) begin
        drive(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        #1;
        check("busy_fault", bus0.fault, 1'b0);
        check("busy_vld", bus0.rd_valid, 1'b0);
        check("busy_data", bus0.data_read, 32'h0);
        check("busy_fault1", bus1.fault, 1'b0);
      end
      if (stop_at > 0 && n0 == stop_at) break;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    #12;
    check("rst_busy0", bus0.busy, 1'b1);
    check("rst_busy1", bus1.busy, 1'b1);
    check("rst_data0", bus0.data_read, 32'h0);
    check("rst_data1", bus1.data_read, 32'h0);
    check("rst_vld1", bus1.rd_valid, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    wait_busy(0, -1, c0, c1);
    check("clear_len0", c0, 256);
    check("clear_len1", c1, 256);

    do_req("rd0_w0",   1, 0, 3'b010, 32'h000, 32'h0, 32'h0, 2'b00);
    do_req("rd0_w4",   1, 0, 3'b010, 32'h010, 32'h0, 32'h0, 2'b00);
    do_req("rd0_top",  1, 0, 3'b010, 32'h3FC, 32'h0, 32'h0, 2'b00);

    do_req("sw10",     0, 1, 3'b010, 32'h010, 32'h8899AABB, 32'h0, 2'b00);
    do_req("lb10",     1, 0, 3'b000, 32'h010, 32'h0, 32'hFFFFFFBB, 2'b00);
    do_req("lbu11",    1, 0, 3'b100, 32'h011, 32'h0, 32'h000000AA, 2'b00);
    do_req("lh12",     1, 0, 3'b001, 32'h012, 32'h0, 32'hFFFF8899, 2'b00);
    do_req("lhu12",    1, 0, 3'b101, 32'h012, 32'h0, 32'h00008899, 2'b00);
    do_req("lw10",     1, 0, 3'b010, 32'h010, 32'h0, 32'h8899AABB, 2'b00);

    do_req("sw20",     0, 1, 3'b010, 32'h020, 32'h0, 32'h0, 2'b00);
    do_req("sb23",     0, 1, 3'b000, 32'h023, 32'hFFFFFF5A, 32'h0, 2'b00);
    do_req("lw20_sb",  1, 0, 3'b010, 32'h020, 32'h0, 32'h5A000000, 2'b00);
    do_req("sh20",     0, 1, 3'b001, 32'h020, 32'hABCD1234, 32'h0, 2'b00);
    do_req("lw20_sh",  1, 0, 3'b010, 32'h020, 32'h0, 32'h5A001234, 2'b00);

    do_req("lw22_mis", 1, 0, 3'b010, 32'h022, 32'h0, 32'h0, 2'b01);
    do_req("sh21_mis", 0, 1, 3'b001, 32'h021, 32'h0000FFFF, 32'h0, 2'b01);
    do_req("lw20_kept",1, 0, 3'b010, 32'h020, 32'h0, 32'h5A001234, 2'b00);
    do_req("f3_011",   1, 0, 3'b011, 32'h020, 32'h0, 32'h0, 2'b11);
    do_req("sbu_ill",  0, 1, 3'b100, 32'h020, 32'hFFFFFFFF, 32'h0, 2'b11);
    do_req("ill_prio", 1, 0, 3'b011, 32'h401, 32'h0, 32'h0, 2'b11);
    do_req("mis_prio", 1, 0, 3'b010, 32'h402, 32'h0, 32'h0, 2'b01);
    do_req("lw400",    1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 2'b10);
    do_req("sw410",    0, 1, 3'b010, 32'h410, 32'hFFFFFFFF, 32'h0, 2'b10);
    do_req("lw10_oor", 1, 0, 3'b010, 32'h010, 32'h0, 32'h8899AABB, 2'b00);
    do_req("lw20_ill", 1, 0, 3'b010, 32'h020, 32'h0, 32'h5A001234, 2'b00);

    do_req("rbw",      1, 1, 3'b010, 32'h010, 32'h11223344, 32'h8899AABB, 2'b00);
    do_req("rbw_new",  1, 0, 3'b010, 32'h010, 32'h0, 32'h11223344, 2'b00);

    do_req("sw0",      0, 1, 3'b010, 32'h000, 32'hCAFEF00D, 32'h0, 2'b00);
    do_req("lw0",      1, 0, 3'b010, 32'h000, 32'h0, 32'h0, 2'b00);
    do_req("lb3",      1, 0, 3'b000, 32'h003, 32'h0, 32'h0, 2'b00);
    idle();
    idle();

    // Restart the clear mid-sequence and check it runs full length again.
    #1 rst_n = 1'b0;
    last_rd1 = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_busy(100, -1, c0, c1);
    check("pre_pulse_cnt", c0, 100);
    #2 rst_n = 1'b0;
    last_rd1 = '0;
    #1;
    check("pulse_busy0", bus0.busy, 1'b1);
    check("pulse_busy1", bus1.busy, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_busy(0, 50, c0, c1);
    check("reclear_len0", c0, 256);
    check("reclear_len1", c1, 256);

    do_req("post_w4",  1, 0, 3'b010, 32'h010, 32'h0, 32'h0, 2'b00);
    do_req("post_w8",  1, 0, 3'b010, 32'h020, 32'h0, 32'h0, 2'b00);
    idle();
    repeat (3) @(posedge clk);
    #1 check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
